// File: rtl/l2_msg_pkg.sv
// l2_msg_pkg: shared types and constants for the L2 input scheduler.
//   - message field widths and packed message width
//   - L2 message type codes (MSG_INV_FWDACK is the one the scheduler decodes)
//   - msg_t message struct, sched_state_e scheduler state
//   - STARVE_LIM: msg1 loss count that forces a msg1 grant when the
//     L2_SCHED_STARVE_GUARD_EN build option is defined
package l2_msg_pkg;

    localparam int TAG_W      = 26;
    localparam int SRC_W      = 6;
    localparam int TYPE_W     = 8;
    localparam int DATA_W     = 64;
    localparam int MSG_W      = TYPE_W + SRC_W + TAG_W + DATA_W;
    localparam int STARVE_LIM = 4;

    localparam logic [TYPE_W-1:0] MSG_LOAD_REQ   = 8'h01;
    localparam logic [TYPE_W-1:0] MSG_STORE_REQ  = 8'h02;
    localparam logic [TYPE_W-1:0] MSG_WB_REQ     = 8'h0c;
    localparam logic [TYPE_W-1:0] MSG_DATA_ACK   = 8'h10;
    localparam logic [TYPE_W-1:0] MSG_WB_ACK     = 8'h12;
    localparam logic [TYPE_W-1:0] MSG_INV_FWDACK = 8'h17;

    typedef struct packed {
        logic [TYPE_W-1:0] mtype;
        logic [SRC_W-1:0]  source;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } msg_t;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } sched_state_e;

endpackage

// File: rtl/l2_issue_slot.sv
// l2_issue_slot: one-entry registered valid/ready buffer holding a message
// plus the channel it came from.
//   clk, rst     clock, synchronous active-high reset
//   load         write in_msg/in_sel this cycle (only when slot_free)
//   in_sel       0 = msg1, 1 = msg3
//   in_msg       packed msg_t
//   out_ready    consumer takes the entry this cycle
//   out_valid    entry held
//   out_sel      channel of the held entry
//   out_msg      held message, stable while out_valid & ~out_ready
//   slot_free    slot can accept a load this cycle
module l2_issue_slot
    import l2_msg_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             in_sel,
    input  logic [MSG_W-1:0] in_msg,
    input  logic             out_ready,
    output logic             out_valid,
    output logic             out_sel,
    output logic [MSG_W-1:0] out_msg,
    output logic             slot_free
);

    assign slot_free = ~out_valid | out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sel   <= 1'b0;
            out_msg   <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_sel   <= in_sel;
            out_msg   <= in_msg;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/l2_msg_sched.sv
// l2_msg_sched: input scheduler for the PMESH L2 single-line datapath.
// Arbitrates msg1 (NoC1 requests) against msg3 (NoC3 responses), registers the
// winner into a one-entry issue slot, and while invalidations are pending
// absorbs all INV_FWDACK responses except the last, which is issued.
//   clk, rst                      clock, synchronous active-high reset
//   msg1_* / msg3_*               request / response channels (valid, ready, fields)
//   issue_valid/ready/sel/fields  issue slot towards the datapath
//   pend_set, pend_cnt            start an invalidation wait for pend_cnt acks
//   busy                          waiting for acks
//   pend_done                     pulse alongside issue of the final ack
//   stray_ack                     sticky: INV_FWDACK seen while not waiting
// Build option L2_SCHED_STARVE_GUARD_EN: after STARVE_LIM consecutive msg1
// losses to msg3, msg1 gets one priority grant.
module l2_msg_sched
    import l2_msg_pkg::*;
#(
    parameter int CNT_W = 7
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              msg1_valid,
    output logic              msg1_ready,
    input  logic [TYPE_W-1:0] msg1_type,
    input  logic [SRC_W-1:0]  msg1_source,
    input  logic [TAG_W-1:0]  msg1_tag,
    input  logic [DATA_W-1:0] msg1_data,
    input  logic              msg3_valid,
    output logic              msg3_ready,
    input  logic [TYPE_W-1:0] msg3_type,
    input  logic [SRC_W-1:0]  msg3_source,
    input  logic [TAG_W-1:0]  msg3_tag,
    input  logic [DATA_W-1:0] msg3_data,
    output logic              issue_valid,
    input  logic              issue_ready,
    output logic              issue_sel,
    output logic [TYPE_W-1:0] issue_type,
    output logic [SRC_W-1:0]  issue_source,
    output logic [TAG_W-1:0]  issue_tag,
    output logic [DATA_W-1:0] issue_data,
    input  logic              pend_set,
    input  logic [CNT_W-1:0]  pend_cnt,
    output logic              busy,
    output logic              pend_done,
    output logic              stray_ack
);

    sched_state_e     state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             pend_done_nxt, stray_nxt;
    logic             slot_free, acc1, acc3, is_ack, cnt_gt1, absorb, load, force1;
    msg_t             m1, m3, load_msg, out_msg;
    logic [MSG_W-1:0] out_bits;

    assign m1      = {msg1_type, msg1_source, msg1_tag, msg1_data};
    assign m3      = {msg3_type, msg3_source, msg3_tag, msg3_data};
    assign is_ack  = (msg3_type == MSG_INV_FWDACK);
    assign cnt_gt1 = (cnt > CNT_W'(1));

`ifdef L2_SCHED_STARVE_GUARD_EN
    localparam int LW = $clog2(STARVE_LIM + 1);
    logic [LW-1:0] loss;

    // Only force when msg1 is actually waiting, so msg3 is never stalled
    // for an absent request.
    assign force1 = (state == IDLE) && (loss == LW'(STARVE_LIM)) && msg1_valid;

    always_ff @(posedge clk) begin
        if (rst || state == PEND || acc1)
            loss <= '0;
        else if (msg1_valid && acc3 && loss != LW'(STARVE_LIM))
            loss <= loss + LW'(1);
    end
`else
    assign force1 = 1'b0;
`endif

    // Readiness. Readies are held low during reset so nothing is taken
    // and then silently dropped.
    always_comb begin
        msg1_ready = 1'b0;
        msg3_ready = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (force1) begin
                        msg1_ready = slot_free;
                    end else begin
                        msg3_ready = slot_free;
                        msg1_ready = slot_free & ~msg3_valid;
                    end
                end
                PEND: begin
                    // Non-final acks never enter the slot, so they need no room.
                    msg3_ready = (is_ack & cnt_gt1) | slot_free;
                end
                default: ;
            endcase
        end
    end

    assign acc1     = msg1_valid & msg1_ready;
    assign acc3     = msg3_valid & msg3_ready;
    assign absorb   = (state == PEND) & acc3 & is_ack & cnt_gt1;
    assign load     = acc1 | (acc3 & ~absorb);
    assign load_msg = acc3 ? m3 : m1;

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        pend_done_nxt = 1'b0;
        stray_nxt     = stray_ack;
        case (state)
            IDLE: begin
                if (acc3 && is_ack)
                    stray_nxt = 1'b1;
                if (pend_set && pend_cnt != '0) begin
                    cnt_nxt   = pend_cnt;
                    state_nxt = PEND;
                end
            end
            PEND: begin
                if (acc3 && is_ack) begin
                    if (cnt_gt1) begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end else begin
                        cnt_nxt       = '0;
                        state_nxt     = IDLE;
                        pend_done_nxt = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            pend_done <= 1'b0;
            stray_ack <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            pend_done <= pend_done_nxt;
            stray_ack <= stray_nxt;
        end
    end

    assign busy = (state == PEND);

    l2_issue_slot u_slot (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .in_sel    (acc3),
        .in_msg    (load_msg),
        .out_ready (issue_ready),
        .out_valid (issue_valid),
        .out_sel   (issue_sel),
        .out_msg   (out_bits),
        .slot_free (slot_free)
    );

    assign out_msg      = msg_t'(out_bits);
    assign issue_type   = out_msg.mtype;
    assign issue_source = out_msg.source;
    assign issue_tag    = out_msg.tag;
    assign issue_data   = out_msg.data;

endmodule

// File: tb/tb_l2_msg_sched.sv
// tb_l2_msg_sched: scoreboard bench for l2_msg_sched. A cycle model of the
// scheduling rules predicts readies/status and pushes expected issues into a
// queue; a negedge monitor compares every presented issue slot against it.
module tb_l2_msg_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        msg1_valid = 1'b0, msg3_valid = 1'b0;
    logic        msg1_ready, msg3_ready;
    logic [7:0]  msg1_type = '0, msg3_type = '0;
    logic [5:0]  msg1_source = '0, msg3_source = '0;
    logic [25:0] msg1_tag = '0, msg3_tag = '0;
    logic [63:0] msg1_data = '0, msg3_data = '0;
    logic        issue_valid, issue_ready = 1'b0, issue_sel;
    logic [7:0]  issue_type;
    logic [5:0]  issue_source;
    logic [25:0] issue_tag;
    logic [63:0] issue_data;
    logic        pend_set = 1'b0;
    logic [6:0]  pend_cnt = '0;
    logic        busy, pend_done, stray_ack;

    l2_msg_sched dut (
        .clk(clk), .rst(rst),
        .msg1_valid(msg1_valid), .msg1_ready(msg1_ready), .msg1_type(msg1_type),
        .msg1_source(msg1_source), .msg1_tag(msg1_tag), .msg1_data(msg1_data),
        .msg3_valid(msg3_valid), .msg3_ready(msg3_ready), .msg3_type(msg3_type),
        .msg3_source(msg3_source), .msg3_tag(msg3_tag), .msg3_data(msg3_data),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_sel(issue_sel),
        .issue_type(issue_type), .issue_source(issue_source), .issue_tag(issue_tag),
        .issue_data(issue_data),
        .pend_set(pend_set), .pend_cnt(pend_cnt),
        .busy(busy), .pend_done(pend_done), .stray_ack(stray_ack)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        sel;
        logic [7:0]  t;
        logic [5:0]  s;
        logic [25:0] g;
        logic [63:0] d;
    } exp_t;

    exp_t q[$];
    int   checks = 0, errors = 0;

    // reference state
    bit m_pend, m_occ, m_stray, m_pd;
    int m_cnt, m_loss;

    task automatic chk(string name, logic [127:0] act, logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Issue-slot monitor: whatever is presented must be the oldest expected
    // message, held until consumed.
    always @(negedge clk) begin
        if (!rst && issue_valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL issue_unexpected: got type %0h, expected nothing", issue_type);
            end else begin
                chk("issue_msg", {issue_sel, issue_type, issue_source, issue_tag, issue_data}, q[0]);
                if (issue_ready) void'(q.pop_front());
            end
        end
    end

    task automatic eval();
        bit free, ack3, e1, e3, a1, a3, frc, n_occ;
        #2;
        free = !m_occ || issue_ready;
        ack3 = (msg3_type == 8'h17);
        frc  = 1'b0;
`ifdef L2_SCHED_STARVE_GUARD_EN
        frc = !m_pend && m_loss >= 4 && msg1_valid;
`endif
        if (rst) begin
            e1 = 0; e3 = 0;
        end else if (!m_pend) begin
            e3 = frc ? 1'b0 : free;
            e1 = frc ? free : (free && !msg3_valid);
        end else begin
            e1 = 0;
            e3 = (ack3 && m_cnt > 1) || free;
        end
        chk("msg1_ready", msg1_ready, e1);
        chk("msg3_ready", msg3_ready, e3);
        chk("issue_valid", issue_valid, m_occ);
        chk("busy", busy, m_pend);
        chk("pend_done", pend_done, m_pd);
        chk("stray_ack", stray_ack, m_stray);
        if (rst) begin
            m_pend = 0; m_occ = 0; m_stray = 0; m_pd = 0; m_cnt = 0; m_loss = 0;
            q.delete();
            return;
        end
        a1 = msg1_valid && e1;
        a3 = msg3_valid && e3;
        n_occ = m_occ && !issue_ready;
        m_pd = 0;
        if (a3) begin
            if (m_pend && ack3 && m_cnt > 1) begin
                m_cnt--;
            end else begin
                q.push_back({1'b1, msg3_type, msg3_source, msg3_tag, msg3_data});
                n_occ = 1;
                if (m_pend && ack3) begin
                    m_cnt = 0; m_pend = 0; m_pd = 1;
                end else if (!m_pend && ack3) begin
                    m_stray = 1;
                end
            end
        end
        if (a1) begin
            q.push_back({1'b0, msg1_type, msg1_source, msg1_tag, msg1_data});
            n_occ = 1;
        end
        if (busy == 1'b0 && !m_pd && pend_set && pend_cnt != 0 && !m_pend) begin
            m_cnt = pend_cnt; m_pend = 1;
        end
        if (busy || m_pd || a1) m_loss = 0;
        else if (a3 && msg1_valid && m_loss < 4) m_loss++;
        m_occ = n_occ;
    endtask

    task automatic tick();
        eval();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        msg1_valid = 0; msg3_valid = 0; pend_set = 0;
        repeat (n) tick();
    endtask

    task automatic rnd_fields();
        msg1_source = 6'($urandom); msg1_tag = 26'($urandom);
        msg1_data   = {$urandom, $urandom};
        msg3_source = 6'($urandom); msg3_tag = 26'($urandom);
        msg3_data   = {$urandom, $urandom};
    endtask

    initial begin
        @(posedge clk); #1;
        repeat (2) tick();
        rst = 0;
        issue_ready = 1;
        idle(1);

        // both channels valid: msg3 wins, msg1 follows
        rnd_fields();
        msg1_type = 8'h01; msg3_type = 8'h10;
        msg1_valid = 1; msg3_valid = 1;
        tick();
        msg3_valid = 0;
        tick();
        idle(3);

        // three acks with msg1 held high: two absorbed, third issued
        pend_set = 1; pend_cnt = 3;
        tick();
        pend_set = 0;
        rnd_fields();
        msg1_valid = 1; msg1_type = 8'h02;
        msg3_valid = 1; msg3_type = 8'h17;
        repeat (3) begin rnd_fields(); tick(); end
        msg3_valid = 0;
        repeat (3) tick();
        idle(2);

        // final ack blocked by a full slot, then released
        issue_ready = 0;
        rnd_fields();
        msg3_valid = 1; msg3_type = 8'h10;
        pend_set = 1; pend_cnt = 1;
        tick();
        pend_set = 0; msg3_type = 8'h17;
        rnd_fields();
        repeat (3) tick();
        issue_ready = 1;
        tick();
        idle(3);

        // stray ack, then reset while waiting on two acks
        rnd_fields();
        msg3_valid = 1; msg3_type = 8'h17;
        tick();
        idle(2);
        pend_set = 1; pend_cnt = 2;
        tick();
        idle(1);
        rst = 1;
        tick();
        rst = 0;
        idle(2);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rnd_fields();
            msg1_valid  = 1'($urandom);
            msg3_valid  = 1'($urandom);
            msg1_type   = 8'($urandom_range(1, 3));
            msg3_type   = ($urandom_range(0, 2) == 0) ? 8'h17 : 8'($urandom_range(16, 18));
            issue_ready = ($urandom_range(0, 3) != 0);
            pend_set    = ($urandom_range(0, 7) == 0);
            pend_cnt    = 7'($urandom_range(0, 4));
            rst         = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst = 0;
        issue_ready = 1;
        idle(6);
        chk("queue_drained", 128'(q.size()), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/l2_msg_sched.md
Name: l2_msg_sched

Overview:
- Input scheduler for the PMESH L2 single-line datapath.
- Arbitrates between the request channel (msg1, NoC1) and the response channel (msg3, NoC3).
- Registers the winning message into a one-entry issue slot.
- Tracks pending invalidation transactions: absorbs all INV_FWDACK responses except the final one, which it forwards.

Parameters:
- TAG_W, 26, message tag width
- SRC_W, 6, message source ID width
- TYPE_W, 8, message type width
- DATA_W, 64, message data width
- CNT_W, 7, outstanding-ack counter width (covers 64 sharers)
- STARVE_LIM, 4, consecutive msg1 losses before a forced msg1 grant (optional feature only)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- msg1_valid  in  1  request valid
- msg1_ready  out  1  request accepted this cycle
- msg1_type/msg1_source/msg1_tag/msg1_data  in  TYPE_W/SRC_W/TAG_W/DATA_W  request fields
- msg3_valid  in  1  response valid
- msg3_ready  out  1  response accepted this cycle
- msg3_type/msg3_source/msg3_tag/msg3_data  in  TYPE_W/SRC_W/TAG_W/DATA_W  response fields
- issue_valid  out  1  issue slot holds a message
- issue_ready  in  1  datapath consumes the slot
- issue_sel  out  1  0 = message came from msg1, 1 = from msg3
- issue_type/issue_source/issue_tag/issue_data  out  widths as above  slot contents
- pend_set  in  1  datapath sent invalidations; enter PEND
- pend_cnt  in  CNT_W  number of acks expected
- busy  out  1  state is PEND
- pend_done  out  1  one-cycle pulse when the final ack is issued
- stray_ack  out  1  sticky flag: INV_FWDACK received outside PEND

Behaviour:
- Reset values: all outputs 0; state IDLE; counter 0; slot empty. Reset mid-PEND drops the pending count with no pend_done.
- Fire conditions: accept = valid & ready on a channel; slot_free = ~issue_valid | issue_ready.
- Slot: loaded the cycle after accept, giving issue_valid one cycle later. Contents are held stable while issue_valid & ~issue_ready.
- IDLE:
  - msg3 has strict priority: msg3_ready = slot_free.
  - msg1_ready = slot_free & ~msg3_valid.
  - An INV_FWDACK (type 8'h17) accepted in IDLE is issued normally and sets stray_ack.
- pend_set (sampled in IDLE only):
  - pend_cnt = 0 is ignored; state stays IDLE.
  - Otherwise the counter loads pend_cnt and the state goes to PEND next cycle.
  - pend_set in PEND is ignored.
- PEND:
  - msg1_ready = 0; msg1 is blocked.
  - INV_FWDACK with counter > 1: msg3_ready = 1 regardless of the slot; the counter decrements and the ack is not issued.
  - INV_FWDACK with counter = 1: msg3_ready = slot_free. On accept, the ack loads into the slot, the counter goes to 0, pend_done pulses in the same cycle the slot loads, and the state returns to IDLE.
  - Other msg3 types: msg3_ready = slot_free; issued normally; counter unchanged.
- pend_set coincident with a msg3 accept in IDLE: the accept proceeds as in IDLE and the counter loads pend_cnt. An ack in that cycle is not counted.
- The counter never underflows; it saturates at 0.

Optional Feature:
- Macro: L2_SCHED_STARVE_GUARD_EN.
- Enabled:
  - A loss counter increments when, in IDLE, msg1_valid and msg3 is accepted.
  - The loss counter clears on any msg1 accept, and in PEND.
  - At STARVE_LIM, msg1 gets priority for one grant: msg3_ready = 0 and msg1_ready = slot_free.
- Disabled: strict msg3 priority; no loss counter logic.

Decomposition:
- Shared package l2_msg_pkg:
  - message type constants (MSG_INV_FWDACK = 8'h17 and the other L2 types)
  - TAG_W, SRC_W, TYPE_W, DATA_W
  - a msg_t struct {type, source, tag, data}
  - a sched_state_e enum {IDLE, PEND}
- One natural sub-module: l2_issue_slot, a one-entry registered valid/ready buffer of msg_t plus a sel bit.

Test Plan:
- Both channels valid in IDLE (msg1 type 8'h01, msg3 type 8'h10), issue_ready=1 → msg3 issued first with issue_sel=1; msg1 issued next with issue_sel=0.
- pend_set with pend_cnt=3, then three INV_FWDACK → first two absorbed (no issue_valid); third issued; pend_done pulses once; busy goes 1→0.
- In PEND, msg1_valid held high → msg1_ready stays 0 until pend_done; the request is issued the cycle after the return to IDLE.
- issue_ready=0 with a final ack pending (counter=1) → msg3_ready=0 and the slot holds its data stable; issue_ready=1 → ack loads, pend_done pulses.
- INV_FWDACK in IDLE → issued normally and stray_ack=1 until rst. Assert rst during PEND with counter=2 → busy=0 and issue_valid=0 next cycle, with no pend_done.
- With L2_SCHED_STARVE_GUARD_EN defined: msg3 streaming plus msg1 valid → msg1 granted on the 5th cycle (after 4 losses).
